localbus_receiver: RTL
======================

// Module: localbus_receiver
// PURPOSE
//  Receive end of the 2-bit localbus (DE/DQ1/DQ0).
//  - Clocked directly by the bus clock; samples on its rising edge, the edge opposite to transmitter launch.
//  - Deserialises units MSB-first: DQ1 carries the odd bit, DQ0 the even bit.
//  - Emits each completed unit, and emits the accumulated frame when DE falls or the unit buffer fills.
//  - Sits at the board/FPGA input, ahead of the command decoder.
// PARAMETERS
//  MAX_UNIT_NUM   4   units held per frame buffer (1..255)
//  UNIT_BIT_NUM   32  bits per unit; must be even, >=2
// PORTS
//  CLK_I            in   1               bus clock (transmitter CLK_O); all logic on posedge
//  RST_I            in   1               synchronous, active-high reset
//  DE_I             in   1               data enable
//  DQ0_I            in   1               even bit of current pair
//  DQ1_I            in   1               odd bit of current pair
//  UNIT_VALID_O     out  1               1-cycle pulse, unit complete (LOCALBUS_RX_UNIT_STREAM_EN)
//  UNIT_DATA_O      out  UNIT_BIT_NUM    completed unit, held until next unit
//  FRAME_VALID_O    out  1               1-cycle pulse, frame complete
//  PDATA_O          out  MAX_UNIT_NUM*UNIT_BIT_NUM  unit k at [k*UNIT_BIT_NUM +: UNIT_BIT_NUM], k=0 first received
//  VALID_UNIT_NUM_O out  8               complete units in PDATA_O, valid with FRAME_VALID_O
//  ERR_O            out  1               1-cycle pulse, DE fell mid-unit (partial unit dropped)
//  BUSY_O           out  1               1 while state==RECV
// BEHAVIOUR
//  Reset values: all outputs 0, buffer 0, unit count 0, pair counter 0, state=SYNC.
//  States:
//   SYNC: wait for DE_I==0, then go to IDLE. Prevents bit misalignment after reset mid-burst.
//   IDLE: when DE_I==1, shift in {DQ1_I,DQ0_I} as bits [UB-1:UB-2], clear buffer and count, go to RECV.
//   RECV, DE_I==1: shift in next pair; pair counter runs 0..UB/2-1.
//   RECV, DE_I==0: end of frame.
//    - Pair counter==0 (aligned): if count>0, FRAME_VALID_O=1; go to IDLE.
//    - Pair counter!=0: ERR_O=1, partial unit discarded; frame still emitted if count>0; go to IDLE.
//  Unit completion: on the edge that samples the last pair (counter==UB/2-1):
//   - UNIT_DATA_O <= {shift,DQ1_I,DQ0_I}; UNIT_VALID_O=1 after that edge (latency 1 edge from last pair sampled).
//   - Unit written to buffer slot [count]; count++.
//  Buffer full: when count reaches MAX_UNIT_NUM, FRAME_VALID_O=1 on the same edge as the last UNIT_VALID_O.
//   - Count resets and buffer clears for the next unit; state stays RECV.
//   - This handles back-to-back frames sent with DE held high.
//  Simultaneous events:
//   - Unit completes on the edge before DE falls: unit counted, frame emitted next edge.
//   - Buffer-full and DE low on same frame: exactly one FRAME_VALID_O, never a second with count 0.
//  PDATA_O/VALID_UNIT_NUM_O are registered with FRAME_VALID_O and held until the next frame pulse.
//   - Unfilled upper units read 0.
//  Count width is 8 bits; no wrap, because the count is capped by MAX_UNIT_NUM.
//  No backpressure: the consumer must accept each pulse.
// CONFIGURATION
//  LOCALBUS_RX_UNIT_STREAM_EN defined:
//   - UNIT_VALID_O/UNIT_DATA_O driven as above (per-unit streaming).
//  LOCALBUS_RX_UNIT_STREAM_EN undefined:
//   - UNIT_VALID_O=0 and UNIT_DATA_O=0 constantly; unit register removed.
//   - Frame path behaviour is identical.
// STRUCTURE
//  localbus_pkg: state encoding (SYNC/IDLE/RECV), pair-counter width, VALID_UNIT_NUM width (8).
//   Shared with the transmitter.
//  Sub-module localbus_rx_deser: shift register + pair counter; outputs unit word and unit_done.
//  Top level holds the FSM, frame buffer and output registers.
// TESTING (MAX_UNIT_NUM=4, UNIT_BIT_NUM=32)
//  1 Single unit 0xA5A5_0F0F, DE high 16 cycles
//    -> UNIT_VALID_O once with 0xA5A50F0F; FRAME_VALID_O; VALID_UNIT_NUM_O=1;
//       PDATA_O[31:0]=0xA5A50F0F, upper units 0.
//  2 Three units 0x1,0x2,0x3 (48 cycles)
//    -> 3 UNIT_VALID_O pulses in order; VALID_UNIT_NUM_O=3; PDATA_O[95:0]=0x3_..._2_..._1.
//  3 DE held high for 8 units 0x10..0x17
//    -> FRAME_VALID_O at unit 4 (0x10..0x13, count 4); then at unit 8 (0x14..0x17);
//       no extra pulse at DE fall.
//  4 DE falls after 5 pairs of unit 2 (unit 1=0xDEADBEEF complete)
//    -> ERR_O pulse; FRAME_VALID_O with count 1, PDATA_O[31:0]=0xDEADBEEF.
//  5 RST_I for 1 cycle mid-burst, DE stays high 10 more cycles then a clean 1-unit frame
//    -> no output during the remaining burst (SYNC); clean frame received correctly.
//  6 Build without LOCALBUS_RX_UNIT_STREAM_EN, rerun scenario 2
//    -> UNIT_VALID_O stays 0, frame outputs identical.

Source files
------------

// File: rtl/localbus_pkg.sv
// localbus_pkg: shared localbus state encoding and widths.
package localbus_pkg;
  typedef enum logic [1:0] {SYNC, IDLE, RECV} lb_state_t;
  localparam int VUN_W = 8;
  function automatic int pcnt_w(input int ub);
    return (ub > 2) ? $clog2(ub / 2) : 1;
  endfunction
endpackage

// File: rtl/localbus_rx_deser.sv
// localbus_rx_deser: MSB-first 2-bit deserialiser with pair counter.
module localbus_rx_deser
  import localbus_pkg::*;
#(
  parameter int UNIT_BIT_NUM = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample,
  input  logic                    dq1,
  input  logic                    dq0,
  output logic [UNIT_BIT_NUM-1:0] word,
  output logic                    unit_done,
  output logic                    mid
);
  localparam int PW = pcnt_w(UNIT_BIT_NUM);
  localparam logic [PW-1:0] LAST = PW'(UNIT_BIT_NUM / 2 - 1);
  logic [PW-1:0] cnt;
  logic [UNIT_BIT_NUM-1:0] sh;
  assign word = UNIT_BIT_NUM'({sh, dq1, dq0});
  assign unit_done = sample && cnt == LAST;
  assign mid = cnt != '0;
  // Counter returns to 0 whenever sampling stops, so a dropped partial unit leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
    end else begin
      cnt <= (!sample || unit_done) ? '0 : cnt + 1'b1;
      if (sample) sh <= word;
    end
  end
endmodule

// File: rtl/localbus_receiver.sv
// localbus_receiver: localbus frame receiver; LOCALBUS_RX_UNIT_STREAM_EN enables per-unit outputs.
module localbus_receiver
  import localbus_pkg::*;
#(
  parameter int MAX_UNIT_NUM = 4,
  parameter int UNIT_BIT_NUM = 32
) (
  input  logic                                 CLK_I,
  input  logic                                 RST_I,
  input  logic                                 DE_I,
  input  logic                                 DQ0_I,
  input  logic                                 DQ1_I,
  output logic                                 UNIT_VALID_O,
  output logic [UNIT_BIT_NUM-1:0]              UNIT_DATA_O,
  output logic                                 FRAME_VALID_O,
  output logic [MAX_UNIT_NUM*UNIT_BIT_NUM-1:0] PDATA_O,
  output logic [VUN_W-1:0]                     VALID_UNIT_NUM_O,
  output logic                                 ERR_O,
  output logic                                 BUSY_O
);
  localparam int FW = MAX_UNIT_NUM * UNIT_BIT_NUM;
  localparam logic [VUN_W-1:0] MU_C = VUN_W'(MAX_UNIT_NUM);
  lb_state_t state, state_n;
  logic [VUN_W-1:0] cnt, cnt_b, cnt_w, cnt_n;
  logic [FW-1:0] fbuf, fb_b, fb_w, fbuf_n;
  logic [UNIT_BIT_NUM-1:0] word;
  logic sample, unit_done, mid, start, eof, full, frame;
  assign sample = DE_I && state != SYNC;
  assign BUSY_O = state == RECV;
  localbus_rx_deser #(.UNIT_BIT_NUM(UNIT_BIT_NUM)) u_deser (
    .clk      (CLK_I),
    .rst      (RST_I),
    .sample   (sample),
    .dq1      (DQ1_I),
    .dq0      (DQ0_I),
    .word     (word),
    .unit_done(unit_done),
    .mid      (mid)
  );
  // A full buffer and end-of-frame both flush, so a DE fall right after a full frame finds count 0.
  always_comb begin
    start = state == IDLE && DE_I;
    eof = state == RECV && !DE_I;
    cnt_b = start ? '0 : cnt;
    fb_b = start ? '0 : fbuf;
    fb_w = fb_b;
    for (int k = 0; k < MAX_UNIT_NUM; k++)
      if (unit_done && cnt_b == VUN_W'(k)) fb_w[k*UNIT_BIT_NUM +: UNIT_BIT_NUM] = word;
    cnt_w = cnt_b + VUN_W'(unit_done);
    full = unit_done && cnt_w == MU_C;
    frame = full || (eof && cnt != '0);
    cnt_n = (full || eof) ? '0 : cnt_w;
    fbuf_n = (full || eof) ? '0 : fb_w;
    state_n = (state == SYNC && DE_I) ? SYNC : DE_I ? RECV : IDLE;
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state            <= SYNC;
      cnt              <= '0;
      fbuf             <= '0;
      FRAME_VALID_O    <= 1'b0;
      ERR_O            <= 1'b0;
      PDATA_O          <= '0;
      VALID_UNIT_NUM_O <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      fbuf          <= fbuf_n;
      FRAME_VALID_O <= frame;
      ERR_O         <= eof && mid;
      if (frame) begin
        PDATA_O          <= fb_w;
        VALID_UNIT_NUM_O <= cnt_w;
      end
    end
  end
`ifdef LOCALBUS_RX_UNIT_STREAM_EN
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      UNIT_VALID_O <= 1'b0;
      UNIT_DATA_O  <= '0;
    end else begin
      UNIT_VALID_O <= unit_done;
      if (unit_done) UNIT_DATA_O <= word;
    end
  end
`else
  assign UNIT_VALID_O = 1'b0;
  assign UNIT_DATA_O  = '0;
`endif
endmodule
